// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared constants and types for the 4x4 keypad driver.
//   CODE_W / NUM_ROWS / NUM_COLS : matrix geometry and key code width
//   scan_result_t                : one full-scan outcome (a key code, NONE or GHOST)
//   key_state_t                  : debounce FSM state
//   ADDR_FIFO / ADDR_STATUS      : CPU register addresses
package keypad_pkg;

  localparam int CODE_W   = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // One extra bit above the key code keeps NONE and GHOST distinct from
  // all sixteen real codes.
  typedef logic [CODE_W:0] scan_result_t;

  localparam scan_result_t RESULT_NONE  = 5'h10;
  localparam scan_result_t RESULT_GHOST = 5'h11;

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } key_state_t;

  localparam logic [1:0] ADDR_FIFO   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b10;

endpackage

// File: rtl/keypad_fifo.sv
// keypad_fifo
// Synchronous circular buffer holding debounced key codes for the CPU.
//   clk, rst_n : clock and synchronous active-low reset
//   push, data : write request and code to store
//   pop        : read request (ignored when empty)
//   head       : oldest stored code
//   full/empty : occupancy flags
//   count      : number of stored codes
// A push into a full buffer is accepted only when a pop happens in the same
// cycle; otherwise it is dropped (the caller detects that case itself).
module keypad_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_driver.sv
// keypad_driver
// Scans a 4x4 matrix keypad, debounces whole-scan results, and queues each
// newly pressed key code for the CPU.
//   iFpgaClock, iCpuResetN : clock and synchronous active-low reset
//   iDoKeypadRead          : one-cycle CPU read strobe
//   iKeypadAddress         : 00 = key FIFO, 10 = status, others read zero
//   oKeypadDataToRead      : combinational read data
//   oKeypadRow             : active-low one-hot row drive
//   iKeypadColumn          : active-low column sense (asynchronous)
//   oKeyAvailable          : FIFO non-empty
module keypad_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 40000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                iFpgaClock,
  input  logic                iCpuResetN,
  input  logic                iDoKeypadRead,
  input  logic [1:0]          iKeypadAddress,
  output logic [15:0]         oKeypadDataToRead,
  output logic [NUM_ROWS-1:0] oKeypadRow,
  input  logic [NUM_COLS-1:0] iKeypadColumn,
  output logic                oKeyAvailable
);

  localparam int DWELL_W  = $clog2(SCAN_DIV);
  localparam int STABLE_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  logic [NUM_COLS-1:0] col_meta;
  logic [NUM_COLS-1:0] col_sync;
  logic [1:0]          row_idx;
  logic [DWELL_W-1:0]  dwell;
  logic                sample;
  logic                scan_done;

  logic [2:0]          row_lows;
  logic [1:0]          row_col;
  logic [1:0]          base_hits;
  logic [1:0]          merged_hits;
  logic [CODE_W-1:0]   merged_code;
  logic [1:0]          acc_hits;
  logic [CODE_W-1:0]   acc_code;
  scan_result_t        scan_result;

  scan_result_t        candidate;
  scan_result_t        cand_next;
  logic [STABLE_W-1:0] stable_cnt;
  logic [STABLE_W-1:0] stable_next;
  logic                debounced;

  key_state_t          fsm_state;
  key_state_t          state_next;
  logic [CODE_W-1:0]   pressed_code;
  logic [CODE_W-1:0]   code_next;
  logic                key_push;

  logic [CODE_W-1:0]   fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_pop;
  logic                status_read;
  logic                overflow;
  logic [2:0]          status_count;

  // Column inputs are asynchronous; nothing below looks at col_meta.
  always_ff @(posedge iFpgaClock) begin
    if (!iCpuResetN) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= iKeypadColumn;
      col_sync <= col_meta;
    end
  end

  assign sample     = (dwell == DWELL_W'(SCAN_DIV - 1));
  assign scan_done  = sample && (row_idx == 2'd3);
  assign oKeypadRow = ~(NUM_ROWS'(1) << row_idx);

  always_ff @(posedge iFpgaClock) begin
    if (!iCpuResetN) begin
      dwell   <= '0;
      row_idx <= '0;
    end else if (sample) begin
      dwell   <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // Low-bit count and lowest low column of the row being sampled.
  always_comb begin
    row_lows = '0;
    row_col  = '0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (!col_sync[c]) begin
        row_lows = row_lows + 3'd1;
        row_col  = 2'(c);
      end
    end
  end

  // Hits saturate at 2 ("two or more"); row 0 starts a fresh scan so stale
  // accumulator contents are never merged in.
  always_comb begin
    base_hits   = (row_idx == 2'd0) ? 2'd0 : acc_hits;
    merged_hits = base_hits;
    merged_code = acc_code;
    if (row_lows == 3'd1 && base_hits == 2'd0) begin
      merged_hits = 2'd1;
      merged_code = {row_idx, row_col};
    end else if (row_lows != 3'd0) begin
      merged_hits = 2'd2;
    end
    case (merged_hits)
      2'd0:    scan_result = RESULT_NONE;
      2'd1:    scan_result = {1'b0, merged_code};
      default: scan_result = RESULT_GHOST;
    endcase
  end

  always_ff @(posedge iFpgaClock) begin
    if (!iCpuResetN) begin
      acc_hits <= '0;
      acc_code <= '0;
    end else if (sample) begin
      acc_hits <= merged_hits;
      acc_code <= merged_code;
    end
  end

  // Debounce bookkeeping; GHOST scans leave candidate and counter untouched.
  always_comb begin
    cand_next   = candidate;
    stable_next = stable_cnt;
    if (scan_done && scan_result != RESULT_GHOST) begin
      if (scan_result == candidate) begin
        if (stable_cnt != STABLE_W'(DEBOUNCE_SCANS)) begin
          stable_next = stable_cnt + 1'b1;
        end
      end else begin
        cand_next   = scan_result;
        stable_next = STABLE_W'(1);
      end
    end
  end

  assign debounced = scan_done && (scan_result != RESULT_GHOST) &&
                     (stable_next == STABLE_W'(DEBOUNCE_SCANS));

  always_ff @(posedge iFpgaClock) begin
    if (!iCpuResetN) begin
      candidate  <= RESULT_NONE;
      stable_cnt <= '0;
    end else begin
      candidate  <= cand_next;
      stable_cnt <= stable_next;
    end
  end

  always_ff @(posedge iFpgaClock) begin
    if (!iCpuResetN) begin
      fsm_state    <= ST_RELEASED;
      pressed_code <= '0;
    end else begin
      fsm_state    <= state_next;
      pressed_code <= code_next;
    end
  end

  // A push happens only on entering a new pressed code, so a held key
  // never repeats however long the counter stays saturated.
  always_comb begin
    state_next = fsm_state;
    code_next  = pressed_code;
    key_push   = 1'b0;
    if (debounced) begin
      case (fsm_state)
        ST_RELEASED: begin
          if (cand_next != RESULT_NONE) begin
            state_next = ST_PRESSED;
            code_next  = cand_next[CODE_W-1:0];
            key_push   = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (cand_next == RESULT_NONE) begin
            state_next = ST_RELEASED;
            code_next  = '0;
          end else if (cand_next[CODE_W-1:0] != pressed_code) begin
            code_next = cand_next[CODE_W-1:0];
            key_push  = 1'b1;
          end
        end
        default: begin
          state_next = ST_RELEASED;
        end
      endcase
    end
  end

  assign fifo_pop    = iDoKeypadRead && (iKeypadAddress == ADDR_FIFO) && !fifo_empty;
  assign status_read = iDoKeypadRead && (iKeypadAddress == ADDR_STATUS);

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk   (iFpgaClock),
    .rst_n (iCpuResetN),
    .push  (key_push),
    .data  (pressed_code_in()),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  function automatic logic [CODE_W-1:0] pressed_code_in();
    return code_next;
  endfunction

  // A dropped push outranks a simultaneous status read so no overflow is lost.
  always_ff @(posedge iFpgaClock) begin
    if (!iCpuResetN) begin
      overflow <= 1'b0;
    end else if (key_push && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (status_read) begin
      overflow <= 1'b0;
    end
  end

  assign status_count  = 3'(fifo_count);
  assign oKeyAvailable = !fifo_empty;

  always_comb begin
    oKeypadDataToRead = 16'h0000;
    if (iKeypadAddress == ADDR_FIFO) begin
      if (!fifo_empty) begin
        oKeypadDataToRead = {1'b1, 11'b0, fifo_head};
      end
    end else if (iKeypadAddress == ADDR_STATUS) begin
      oKeypadDataToRead = {overflow, 6'b0, (fsm_state == ST_PRESSED),
                           pressed_code, 1'b0, status_count};
    end
  end

endmodule

// File: tb/tb_keypad_driver.sv
// tb_keypad_driver
// Self-checking bench for keypad_driver (SCAN_DIV=4, DEBOUNCE_SCANS=2,
// FIFO_DEPTH=4). A simple key-matrix model drives the columns from the row
// drive; every scan is aligned to reset release (16 cycles per scan).
module tb_keypad_driver;

  localparam int SCAN_DIV    = 4;
  localparam int DEB_SCANS   = 2;
  localparam int DEPTH       = 4;
  localparam int SCAN_CYCLES = 4 * SCAN_DIV;
  localparam int RES_NONE    = -1;
  localparam int RES_GHOST   = -2;

  logic        iFpgaClock     = 1'b0;
  logic        iCpuResetN     = 1'b0;
  logic        iDoKeypadRead  = 1'b0;
  logic [1:0]  iKeypadAddress = 2'b00;
  logic [15:0] oKeypadDataToRead;
  logic [3:0]  oKeypadRow;
  logic [3:0]  iKeypadColumn;
  logic        oKeyAvailable;
  logic [15:0] key_mask = 16'h0000;

  int errors = 0;
  int checks = 0;

  int mq[$];
  int m_cand    = RES_NONE;
  int m_cnt     = 0;
  int m_pressed = RES_NONE;
  bit m_ovf     = 1'b0;

  typedef struct {
    logic [15:0] keys;
    int          rcyc;
    logic [1:0]  raddr;
    logic [15:0] exp_rd;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[$];

  keypad_driver #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB_SCANS),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .iFpgaClock        (iFpgaClock),
    .iCpuResetN        (iCpuResetN),
    .iDoKeypadRead     (iDoKeypadRead),
    .iKeypadAddress    (iKeypadAddress),
    .oKeypadDataToRead (oKeypadDataToRead),
    .oKeypadRow        (oKeypadRow),
    .iKeypadColumn     (iKeypadColumn),
    .oKeyAvailable     (oKeyAvailable)
  );

  always #5 iFpgaClock = ~iFpgaClock;

  // A pressed key connects its row to its column; driven row is low.
  always_comb begin
    iKeypadColumn = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_mask[4 * r + c] && !oKeypadRow[r]) begin
          iKeypadColumn[c] = 1'b0;
        end
      end
    end
  end

  function automatic logic [15:0] kb(input int k);
    return 16'h0001 << k;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Reference model: works on whole-scan outcomes and a queue of codes.
  function automatic int scan_result(input logic [15:0] keys);
    int n   = 0;
    int idx = 0;
    for (int k = 0; k < 16; k++) begin
      if (keys[k]) begin
        n++;
        idx = k;
      end
    end
    if (n == 0) return RES_NONE;
    if (n == 1) return idx;
    return RES_GHOST;
  endfunction

  function automatic logic [15:0] model_data(input logic [1:0] addr);
    logic [15:0] d;
    d = 16'h0000;
    if (addr == 2'b00) begin
      if (mq.size() > 0) d = {1'b1, 11'b0, 4'(mq[0])};
    end else if (addr == 2'b10) begin
      d[15]  = m_ovf;
      d[8]   = (m_pressed >= 0);
      if (m_pressed >= 0) d[7:4] = 4'(m_pressed);
      d[2:0] = 3'(mq.size());
    end
    return d;
  endfunction

  function automatic void model_read(input logic [1:0] addr);
    if (addr == 2'b00 && mq.size() > 0) void'(mq.pop_front());
    if (addr == 2'b10) m_ovf = 1'b0;
  endfunction

  function automatic void model_scan(input int res);
    if (res == RES_GHOST) return;
    if (res == m_cand) begin
      if (m_cnt < DEB_SCANS) m_cnt++;
    end else begin
      m_cand = res;
      m_cnt  = 1;
    end
    if (m_cnt == DEB_SCANS) begin
      if (m_cand == RES_NONE) begin
        m_pressed = RES_NONE;
      end else if (m_pressed != m_cand) begin
        m_pressed = m_cand;
        if (mq.size() < DEPTH) mq.push_back(m_cand);
        else m_ovf = 1'b1;
      end
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_cand    = RES_NONE;
    m_cnt     = 0;
    m_pressed = RES_NONE;
    m_ovf     = 1'b0;
  endfunction

  task automatic peekStatus(output logic [15:0] s);
    iKeypadAddress = 2'b10;
    #1;
    s = oKeypadDataToRead;
  endtask

  task automatic checkState(input string tag);
    logic exp_av;
    exp_av = (mq.size() > 0);
    iKeypadAddress = 2'b10;
    #1;
    checkOutput({tag, "_status"}, oKeypadDataToRead, model_data(2'b10));
    iKeypadAddress = 2'b00;
    #1;
    checkOutput({tag, "_head"}, oKeypadDataToRead, model_data(2'b00));
    checkOutput({tag, "_avail"}, {15'b0, oKeyAvailable}, {15'b0, exp_av});
  endtask

  // One full scan with a fixed key set; optional strobed read on cycle rcyc.
  task automatic applyStimulus(input logic [15:0] keys, input int rcyc,
                               input logic [1:0] raddr, output logic [15:0] rdata);
    key_mask = keys;
    rdata    = 16'h0000;
    for (int cyc = 0; cyc < SCAN_CYCLES; cyc++) begin
      if (cyc == rcyc) begin
        iKeypadAddress = raddr;
        iDoKeypadRead  = 1'b1;
        #1;
        rdata = oKeypadDataToRead;
        checkOutput("read_data", oKeypadDataToRead, model_data(raddr));
        model_read(raddr);
      end
      @(posedge iFpgaClock);
      #1;
      iDoKeypadRead = 1'b0;
    end
    model_scan(scan_result(keys));
    checkState("scan");
  endtask

  task automatic add_vec(input logic [15:0] keys, input int rcyc, input logic [1:0] raddr,
                         input logic [15:0] exp_rd, input logic [2:0] exp_count);
    vec_t v;
    v.keys      = keys;
    v.rcyc      = rcyc;
    v.raddr     = raddr;
    v.exp_rd    = exp_rd;
    v.exp_count = exp_count;
    vecs.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] st;
    logic [15:0] cur;
    int          hold;
    int          pick;
    int          a;
    int          b;
    int          rc;
    logic [1:0]  ra;

    // Single held key, status and empty reads, unused addresses.
    add_vec(kb(9), -1, 2'b00, 16'h0000, 3'd0);
    add_vec(kb(9), -1, 2'b00, 16'h0000, 3'd1);
    add_vec(kb(9),  2, 2'b10, 16'h0191, 3'd1);
    add_vec(kb(9), -1, 2'b00, 16'h0000, 3'd1);
    add_vec(16'h0,  2, 2'b00, 16'h8009, 3'd0);
    add_vec(16'h0,  2, 2'b00, 16'h0000, 3'd0);
    add_vec(16'h0,  2, 2'b10, 16'h0000, 3'd0);
    // Five keys back to back with no reads; the fifth overflows.
    add_vec(kb(1), -1, 2'b00, 16'h0000, 3'd0);
    add_vec(kb(1), -1, 2'b00, 16'h0000, 3'd1);
    add_vec(kb(2), -1, 2'b00, 16'h0000, 3'd1);
    add_vec(kb(2), -1, 2'b00, 16'h0000, 3'd2);
    add_vec(kb(3), -1, 2'b00, 16'h0000, 3'd2);
    add_vec(kb(3), -1, 2'b00, 16'h0000, 3'd3);
    add_vec(kb(4), -1, 2'b00, 16'h0000, 3'd3);
    add_vec(kb(4), -1, 2'b00, 16'h0000, 3'd4);
    add_vec(kb(5), -1, 2'b00, 16'h0000, 3'd4);
    add_vec(kb(5), -1, 2'b00, 16'h0000, 3'd4);
    add_vec(16'h0,  3, 2'b10, 16'h8154, 3'd4);
    add_vec(16'h0,  3, 2'b10, 16'h0154, 3'd4);
    add_vec(16'h0,  5, 2'b01, 16'h0000, 3'd4);
    add_vec(16'h0,  5, 2'b11, 16'h0000, 3'd4);
    add_vec(16'h0,  7, 2'b00, 16'h8001, 3'd3);
    add_vec(16'h0,  7, 2'b00, 16'h8002, 3'd2);
    add_vec(16'h0,  7, 2'b00, 16'h8003, 3'd1);
    add_vec(16'h0,  7, 2'b00, 16'h8004, 3'd0);
    add_vec(16'h0,  7, 2'b00, 16'h0000, 3'd0);
    add_vec(16'h0,  7, 2'b10, 16'h0000, 3'd0);

    $display("[TB] reset");
    repeat (2) @(posedge iFpgaClock);
    #1;
    checkOutput("reset_row", {12'b0, oKeypadRow}, 16'h000E);
    checkOutput("reset_avail", {15'b0, oKeyAvailable}, 16'h0000);
    peekStatus(st);
    checkOutput("reset_status", st, 16'h0000);
    iCpuResetN = 1'b1;
    model_reset();

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].keys, vecs[i].rcyc, vecs[i].raddr, rd);
      if (vecs[i].rcyc >= 0) checkOutput($sformatf("vec%0d_read", i), rd, vecs[i].exp_rd);
      peekStatus(st);
      checkOutput($sformatf("vec%0d_count", i), {13'b0, st[2:0]}, {13'b0, vecs[i].exp_count});
    end

    $display("[TB] bouncing key");
    for (int s = 0; s < 6; s++) applyStimulus((s % 2 == 0) ? kb(5) : 16'h0, -1, 2'b00, rd);
    repeat (2) applyStimulus(16'h0, -1, 2'b00, rd);
    peekStatus(st);
    checkOutput("bounce_status", st, 16'h0000);

    $display("[TB] ghost pair");
    repeat (4) applyStimulus(kb(3) | kb(12), -1, 2'b00, rd);
    peekStatus(st);
    checkOutput("ghost_status", st, 16'h0000);
    checkOutput("ghost_avail", {15'b0, oKeyAvailable}, 16'h0000);
    repeat (2) applyStimulus(16'h0, -1, 2'b00, rd);

    $display("[TB] pop coincides with push");
    for (int k = 1; k <= 4; k++) repeat (2) applyStimulus(kb(k), -1, 2'b00, rd);
    applyStimulus(kb(7), -1, 2'b00, rd);
    applyStimulus(kb(7), SCAN_CYCLES - 1, 2'b00, rd);
    checkOutput("coincide_read", rd, 16'h8001);
    peekStatus(st);
    checkOutput("coincide_status", st, 16'h0174);
    repeat (2) applyStimulus(16'h0, -1, 2'b00, rd);
    applyStimulus(16'h0, 4, 2'b00, rd);
    checkOutput("drain_read2", rd, 16'h8002);
    applyStimulus(16'h0, 4, 2'b00, rd);
    checkOutput("drain_read3", rd, 16'h8003);
    applyStimulus(16'h0, 4, 2'b00, rd);
    checkOutput("drain_read4", rd, 16'h8004);
    applyStimulus(16'h0, 4, 2'b00, rd);
    checkOutput("drain_last", rd, 16'h8007);
    peekStatus(st);
    checkOutput("drain_status", st, 16'h0000);

    $display("[TB] reset mid-scan");
    applyStimulus(kb(0), -1, 2'b00, rd);
    key_mask = kb(0);
    repeat (9) begin
      @(posedge iFpgaClock);
      #1;
    end
    checkOutput("pre_reset_row", {12'b0, oKeypadRow}, 16'h000B);
    iCpuResetN = 1'b0;
    @(posedge iFpgaClock);
    #1;
    iCpuResetN = 1'b1;
    model_reset();
    checkOutput("midreset_row", {12'b0, oKeypadRow}, 16'h000E);
    checkOutput("midreset_avail", {15'b0, oKeyAvailable}, 16'h0000);
    applyStimulus(kb(0), -1, 2'b00, rd);
    checkOutput("fresh_scan1_avail", {15'b0, oKeyAvailable}, 16'h0000);
    applyStimulus(kb(0), -1, 2'b00, rd);
    checkOutput("fresh_scan2_avail", {15'b0, oKeyAvailable}, 16'h0001);
    applyStimulus(16'h0, 3, 2'b00, rd);
    checkOutput("fresh_read", rd, 16'h8000);

    $display("[TB] randomized scans");
    cur  = 16'h0;
    hold = 0;
    for (int s = 0; s < 200; s++) begin
      if (hold == 0) begin
        pick = int'($urandom_range(0, 9));
        if (pick < 5) begin
          cur = kb(int'($urandom_range(0, 15)));
        end else if (pick < 8) begin
          cur = 16'h0;
        end else begin
          a   = int'($urandom_range(0, 15));
          b   = (a + int'($urandom_range(1, 15))) % 16;
          cur = kb(a) | kb(b);
        end
        hold = int'($urandom_range(1, 4));
      end
      hold--;
      rc = -1;
      ra = 2'b00;
      if ($urandom_range(0, 9) < 4) begin
        rc = int'($urandom_range(0, SCAN_CYCLES - 1));
        if ($urandom_range(0, 3) == 0) ra = 2'($urandom_range(0, 3));
      end
      applyStimulus(cur, rc, ra, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_driver.md
KEYPAD_DRIVER -- requirements
Module: keypad_driver

Interface
REQ-001 Parameter SCAN_DIV, default 40000, iFpgaClock cycles each keypad row is driven before its columns are sampled (minimum 2).
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive identical full-scan results required before a key state is accepted (minimum 1).
REQ-003 Parameter FIFO_DEPTH, default 4, number of key codes buffered for the CPU.
REQ-004 iFpgaClock  in  1  the only clock; all logic SHALL be rising-edge.
REQ-005 iCpuResetN  in  1  synchronous, active-low reset.
REQ-006 iDoKeypadRead  in  1  CPU read strobe, one cycle per access.
REQ-007 iKeypadAddress  in  2  2'b00 selects the key FIFO; 2'b10 selects status; other values read 16'h0000.
REQ-008 oKeypadDataToRead  out  16  read data, combinational from the address and current state.
REQ-009 oKeypadRow  out  4  active-low one-hot row drive.
REQ-010 iKeypadColumn  in  4  active-low column sense, externally pulled up, asynchronous to iFpgaClock.
REQ-011 oKeyAvailable  out  1  high while the FIFO is non-empty.

Function
REQ-012 iKeypadColumn SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Row scan: row counter r (0..3) drives oKeypadRow = ~(1<<r) for SCAN_DIV cycles; synchronized columns are sampled on dwell count SCAN_DIV-1; r then increments, wrapping 3->0.
REQ-014 Key code = 4*r + c, where c is the index of the low column bit.
REQ-015 Scan result after sampling row 3: exactly one low bit across all 16 samples -> that code; none -> NONE; two or more -> GHOST.
REQ-016 GHOST results SHALL be ignored: no change to the debounce counter or the candidate.
REQ-017 Debounce: a result equal to the previous candidate increments a stable counter saturating at DEBOUNCE_SCANS; a different result replaces the candidate and sets the counter to 1.
REQ-018 Debounce FSM states are RELEASED and PRESSED(code).
REQ-019 RELEASED -> PRESSED(K) when counter reaches DEBOUNCE_SCANS with candidate K; this SHALL push K into the FIFO on the same cycle.
REQ-020 PRESSED(K) -> RELEASED on a stable NONE.
REQ-021 PRESSED(K) -> PRESSED(J) on a stable J != K; this pushes J.
REQ-022 A held key SHALL NOT auto-repeat.
REQ-023 Read at address 0: data = {1'b1, 11'b0, head code} when non-empty, otherwise 16'h0000; a strobed read of a non-empty FIFO pops one entry at the clock edge.
REQ-024 Read at address 2: data = {overflow, 6'b0, pressed, stable code[3:0], 1'b0, count[2:0]}; a strobed status read clears overflow at the clock edge.
REQ-025 A push into a full FIFO is dropped and sets the sticky overflow bit, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-026 Simultaneous push and pop on a non-empty FIFO leaves count unchanged and preserves order.
REQ-027 Pop on an empty FIFO has no effect.

Reset
REQ-028 While iCpuResetN is low at a clock edge: r=0, oKeypadRow=4'b1110, dwell counter 0, synchronizers 1111, candidate NONE, stable counter 0, FSM RELEASED, FIFO empty, overflow 0, oKeyAvailable 0.
REQ-029 Reset mid-scan or mid-debounce SHALL discard all partial results; scanning restarts at row 0 in the first cycle after release.

Structure
REQ-030 Package keypad_pkg holds: code width 4, row/column count 4, NONE/GHOST encodings, FSM state encoding, and the address constants 2'b00 / 2'b10.
REQ-031 The buffer SHALL be a separate sub-module keypad_fifo (synchronous, FIFO_DEPTH entries, push/pop/full/empty/count).

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2; one full scan = 16 cycles)
REQ-032 Hold key row 2 col 1 (code 9) for 4 scans: exactly one push; address-0 read returns 16'h8009; next read returns 16'h0000.
REQ-033 Key 5 bounces, alternating pressed/released every scan for 6 scans, then is released: no push, status count 0.
REQ-034 Press keys 3 and 12 together for 4 scans (GHOST): no push; FSM stays RELEASED.
REQ-035 Enter 5 distinct debounced keys 1,2,3,4,5 with no reads: reads return 1,2,3,4 in order; status bit 15 = 1 and is cleared after the status read.
REQ-036 FIFO full; a pop coincides with the debounced push of key 7: count stays 4, the last read returns 16'h8007, overflow stays 0.
REQ-037 Assert reset for 1 cycle during row 2 of a scan with key 0 held: oKeypadRow=4'b1110 next cycle, FIFO empty, key 0 pushed only after 2 fresh full scans.
